pong_sequencer: RTL and testbench

- Frame-rate game-flow controller that sequences the Pong datapath: attract → serve → play → point-lost → game-over.
- Sits between the VGA timing generator (frame_start), the Pong game logic (enable, serve, miss/hit events) and the final colour compositor (background colour).
- Owns score, lives and a debounced start button, so the game logic only moves objects when told to.

---
 rtl/pong_sequencer_if.sv | 26 ++
 rtl/pong_sequencer.sv | 143 ++++++++++++++
 tb/tb_pong_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pong_sequencer_if.sv
// Signal bundle between the Pong game-flow sequencer and the rest of the system.
// The master side is the sequencer. The slave side is the timing generator, game logic and compositor.
interface pong_sequencer_if #(
   parameter int SCORE_W = 4
);
   logic               frame_start;
   logic               start_btn;
   logic               ball_missed;
   logic               paddle_hit;
   logic               game_en;
   logic               serve;
   logic [SCORE_W-1:0] score;
   logic [2:0]         lives;
   logic [2:0]         state;
   logic [11:0]        bg_color;

   modport master (
      input  frame_start, start_btn, ball_missed, paddle_hit,
      output game_en, serve, score, lives, state, bg_color
   );

   modport slave (
      output frame_start, start_btn, ball_missed, paddle_hit,
      input  game_en, serve, score, lives, state, bg_color
   );
endinterface

// File: rtl/pong_sequencer.sv
// Frame-rate game-flow controller for Pong: attract, serve, play, point-lost, game-over.
// It owns score, lives, a frame counter and the debounced start button. All outputs are registered.
module pong_sequencer #(
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90,
   parameter int LIVES        = 3,
   parameter int SCORE_W      = 4
) (
   input  logic             clk,
   input  logic             reset,
   pong_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SERVE    = 3'd1,
      ST_PLAY     = 3'd2,
      ST_POINT    = 3'd3,
      ST_GAMEOVER = 3'd4
   } state_t;

   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
   localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);
   localparam logic [7:0]         POINT_LAST = 8'(POINT_FRAMES - 1);
   localparam logic [7:0]         CNT_MAX    = 8'hFF;
   localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
   localparam logic [11:0]        BG_BLUE    = 12'h00F;
   localparam logic [11:0]        BG_RED     = 12'hF00;
   localparam logic [11:0]        BG_WHITE   = 12'hFFF;
   localparam logic [11:0]        BG_GREY    = 12'h444;

   logic               sync1_q, sync2_q;
   logic               btn_sample_q, btn_sample_d;
   state_t             state_q, state_d;
   logic [7:0]         frame_cnt_q, frame_cnt_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [2:0]         lives_q, lives_d;
   logic               game_en_q, game_en_d;
   logic               serve_q, serve_d;
   logic [11:0]        bg_color_q, bg_color_d;
   logic               press;

   // The button is sampled only at frame rate, so contact bounce shorter than a frame is ignored.
   always_comb begin
      press        = bus.frame_start & sync2_q & ~btn_sample_q;
      btn_sample_d = bus.frame_start ? sync2_q : btn_sample_q;
   end

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      lives_d = lives_q;
      unique case (state_q)
         ST_IDLE, ST_GAMEOVER: begin
            if (press) begin
               state_d = ST_SERVE;
               score_d = '0;
               lives_d = LIVES_INIT;
            end
         end
         ST_SERVE: begin
            if (bus.frame_start && frame_cnt_q == SERVE_LAST) begin
               state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            // A miss takes priority over a simultaneous hit.
            if (bus.ball_missed) begin
               state_d = ST_POINT;
               if (lives_q != 3'd0) begin
                  lives_d = lives_q - 3'd1;
               end
            end else if (bus.paddle_hit && score_q != SCORE_MAX) begin
               score_d = score_q + 1'b1;
            end
         end
         ST_POINT: begin
            if (bus.frame_start && frame_cnt_q == POINT_LAST) begin
               state_d = (lives_q != 3'd0) ? ST_SERVE : ST_GAMEOVER;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (state_d != state_q) begin
         frame_cnt_d = 8'd0;
      end else if (bus.frame_start && frame_cnt_q != CNT_MAX) begin
         frame_cnt_d = frame_cnt_q + 8'd1;
      end
   end

   // Outputs are decoded from next-state values so they change on the same edge as state.
   always_comb begin
      serve_d    = (state_q == ST_SERVE) && (state_d == ST_PLAY);
      game_en_d  = (state_d == ST_PLAY);
      bg_color_d = BG_BLUE;
      unique case (state_d)
         ST_IDLE:     bg_color_d = BG_BLUE;
         ST_SERVE:    bg_color_d = BG_RED;
         ST_PLAY:     bg_color_d = BG_RED;
         ST_POINT:    bg_color_d = frame_cnt_d[3] ? BG_WHITE : BG_RED;
         ST_GAMEOVER: bg_color_d = BG_GREY;
         default:     bg_color_d = BG_BLUE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         btn_sample_q <= 1'b0;
         state_q      <= ST_IDLE;
         frame_cnt_q  <= 8'd0;
         score_q      <= '0;
         lives_q      <= LIVES_INIT;
         game_en_q    <= 1'b0;
         serve_q      <= 1'b0;
         bg_color_q   <= BG_BLUE;
      end else begin
         sync1_q      <= bus.start_btn;
         sync2_q      <= sync1_q;
         btn_sample_q <= btn_sample_d;
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
         game_en_q    <= game_en_d;
         serve_q      <= serve_d;
         bg_color_q   <= bg_color_d;
      end
   end

   assign bus.game_en  = game_en_q;
   assign bus.serve    = serve_q;
   assign bus.score    = score_q;
   assign bus.lives    = lives_q;
   assign bus.state    = state_q;
   assign bus.bg_color = bg_color_q;

endmodule

// File: tb/tb_pong_sequencer.sv
// Directed bench for pong_sequencer: a table of single-cycle PLAY/POINT vectors,
// plus hand-written serve, point, game-over and asynchronous-reset sequences.
module tb_pong_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;

   pong_sequencer_if #(.SCORE_W(4)) bus ();

   pong_sequencer #(
      .SERVE_FRAMES(60),
      .POINT_FRAMES(90),
      .LIVES(3),
      .SCORE_W(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fs, btn, miss, hit;
      logic [2:0]  st;
      logic [3:0]  score;
      logic [2:0]  lives;
      logic        en, srv;
      logic [11:0] bg;
   } vec_t;

   vec_t tbl [30];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      bus.frame_start = 1'b1;
      cyc();
      bus.frame_start = 1'b0;
      cyc();
      cyc();
      cyc();
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [2:0] st, input logic [3:0] score,
                            input logic [2:0] lives, input logic en, input logic srv,
                            input logic [11:0] bg);
      check({name, ".state"}, 32'(bus.state), 32'(st));
      check({name, ".score"}, 32'(bus.score), 32'(score));
      check({name, ".lives"}, 32'(bus.lives), 32'(lives));
      check({name, ".game_en"}, 32'(bus.game_en), 32'(en));
      check({name, ".serve"}, 32'(bus.serve), 32'(srv));
      check({name, ".bg"}, 32'(bus.bg_color), 32'(bg));
   endtask

   // Starts with `done` frames already spent in SERVE. It ends one cycle after the SERVE->PLAY edge.
   task automatic run_serve(input int done, input logic [3:0] score, input logic [2:0] lives,
                            input bit reset_on_serve);
      for (int k = done + 1; k < 60; k++) frame();
      check_all("serve_wait", 3'd1, score, lives, 1'b0, 1'b0, 12'hF00);
      bus.frame_start = 1'b1;
      cyc();
      bus.frame_start = 1'b0;
      check_all("serve_launch", 3'd2, score, lives, 1'b1, 1'b1, 12'hF00);
      if (reset_on_serve) begin
         reset = 1'b1;
         #1;
         check_all("reset_drops_serve", 3'd0, 4'd0, 3'd3, 1'b0, 1'b0, 12'h00F);
         cyc();
         cyc();
         reset = 1'b0;
      end else begin
         cyc();
         check_all("serve_done", 3'd2, score, lives, 1'b1, 1'b0, 12'hF00);
      end
   endtask

   // Starts in POINT with the counter at 0. It runs all 90 frames and checks the flash and the exit state.
   task automatic point_phase(input logic [3:0] score, input logic [2:0] lives, input logic [2:0] exit_st);
      for (int k = 1; k <= 90; k++) begin
         frame();
         if (k < 90) begin
            check($sformatf("point_f%0d.state", k), 32'(bus.state), 32'd3);
            check($sformatf("point_f%0d.bg", k), 32'(bus.bg_color),
                  ((k & 8) != 0) ? 32'hFFF : 32'hF00);
         end
      end
      check_all("point_exit", exit_st, score, lives, 1'b0, 1'b0,
                (exit_st == 3'd4) ? 12'h444 : 12'hF00);
   endtask

   task automatic press_start();
      bus.start_btn = 1'b1;
      cyc();
      cyc();
      cyc();
      frame();
      bus.start_btn = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Table of one-cycle vectors applied starting in PLAY with score 0 and lives 3.
      tbl[0] = '{0, 0, 0, 1, 3'd2, 4'd1, 3'd3, 1, 0, 12'hF00};
      tbl[1] = '{0, 0, 0, 1, 3'd2, 4'd2, 3'd3, 1, 0, 12'hF00};
      tbl[2] = '{0, 0, 0, 0, 3'd2, 4'd2, 3'd3, 1, 0, 12'hF00};
      tbl[3] = '{0, 0, 0, 1, 3'd2, 4'd3, 3'd3, 1, 0, 12'hF00};
      tbl[4] = '{0, 0, 0, 1, 3'd2, 4'd4, 3'd3, 1, 0, 12'hF00};
      tbl[5] = '{1, 0, 0, 1, 3'd2, 4'd5, 3'd3, 1, 0, 12'hF00};
      tbl[6] = '{1, 0, 0, 0, 3'd2, 4'd5, 3'd3, 1, 0, 12'hF00};
      for (int i = 0; i < 20; i++) begin
         n = (6 + i > 15) ? 15 : 6 + i;
         tbl[7 + i] = '{0, 0, 0, 1, 3'd2, 4'(n), 3'd3, 1, 0, 12'hF00};
      end
      tbl[27] = '{0, 0, 1, 1, 3'd3, 4'd15, 3'd2, 0, 0, 12'hF00};
      tbl[28] = '{0, 0, 1, 1, 3'd3, 4'd15, 3'd2, 0, 0, 12'hF00};
      tbl[29] = '{0, 0, 0, 1, 3'd3, 4'd15, 3'd2, 0, 0, 12'hF00};

      bus.frame_start = 1'b0;
      bus.start_btn   = 1'b0;
      bus.ball_missed = 1'b0;
      bus.paddle_hit  = 1'b0;
      #1 reset = 1'b1;
      #2;
      check_all("reset", 3'd0, 4'd0, 3'd3, 1'b0, 1'b0, 12'h00F);
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
      frame();
      check_all("idle_no_press", 3'd0, 4'd0, 3'd3, 1'b0, 1'b0, 12'h00F);

      // Hold the button across three frames. Only the first frame registers a press.
      bus.start_btn = 1'b1;
      cyc();
      cyc();
      cyc();
      check_all("before_press", 3'd0, 4'd0, 3'd3, 1'b0, 1'b0, 12'h00F);
      frame();
      check_all("press_serve", 3'd1, 4'd0, 3'd3, 1'b0, 1'b0, 12'hF00);
      frame();
      frame();
      check_all("held_btn", 3'd1, 4'd0, 3'd3, 1'b0, 1'b0, 12'hF00);
      bus.start_btn = 1'b0;
      run_serve(2, 4'd0, 3'd3, 1'b0);

      for (int i = 0; i < 30; i++) begin
         bus.frame_start = tbl[i].fs;
         bus.start_btn   = tbl[i].btn;
         bus.ball_missed = tbl[i].miss;
         bus.paddle_hit  = tbl[i].hit;
         cyc();
         bus.frame_start = 1'b0;
         bus.ball_missed = 1'b0;
         bus.paddle_hit  = 1'b0;
         $display("[TB] vec %0d fs=%0b miss=%0b hit=%0b -> state=%0d score=%0d lives=%0d bg=%03h",
                  i, tbl[i].fs, tbl[i].miss, tbl[i].hit, bus.state, bus.score, bus.lives, bus.bg_color);
         check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].score, tbl[i].lives,
                   tbl[i].en, tbl[i].srv, tbl[i].bg);
      end
      point_phase(4'd15, 3'd2, 3'd1);

      // Second life is lost on a miss that coincides with frame_start. That pulse must not be counted.
      run_serve(0, 4'd15, 3'd2, 1'b0);
      bus.ball_missed = 1'b1;
      bus.frame_start = 1'b1;
      cyc();
      bus.ball_missed = 1'b0;
      bus.frame_start = 1'b0;
      check_all("miss_fs", 3'd3, 4'd15, 3'd1, 1'b0, 1'b0, 12'hF00);
      point_phase(4'd15, 3'd1, 3'd1);

      run_serve(0, 4'd15, 3'd1, 1'b0);
      bus.ball_missed = 1'b1;
      cyc();
      bus.ball_missed = 1'b0;
      check_all("last_miss", 3'd3, 4'd15, 3'd0, 1'b0, 1'b0, 12'hF00);
      point_phase(4'd15, 3'd0, 3'd4);

      bus.ball_missed = 1'b1;
      bus.paddle_hit  = 1'b1;
      cyc();
      bus.ball_missed = 1'b0;
      bus.paddle_hit  = 1'b0;
      frame();
      check_all("gameover_ignore", 3'd4, 4'd15, 3'd0, 1'b0, 1'b0, 12'h444);

      press_start();
      check_all("restart", 3'd1, 4'd0, 3'd3, 1'b0, 1'b0, 12'hF00);
      run_serve(0, 4'd0, 3'd3, 1'b0);
      for (int i = 0; i < 7; i++) begin
         bus.paddle_hit = 1'b1;
         cyc();
         bus.paddle_hit = 1'b0;
         cyc();
      end
      check_all("score7", 3'd2, 4'd7, 3'd3, 1'b1, 1'b0, 12'hF00);
      #2 reset = 1'b1;
      #1;
      check_all("async_reset", 3'd0, 4'd0, 3'd3, 1'b0, 1'b0, 12'h00F);
      cyc();
      cyc();
      reset = 1'b0;
      cyc();

      press_start();
      check_all("restart2", 3'd1, 4'd0, 3'd3, 1'b0, 1'b0, 12'hF00);
      run_serve(0, 4'd0, 3'd3, 1'b1);
      cyc();
      check_all("after_reset", 3'd0, 4'd0, 3'd3, 1'b0, 1'b0, 12'h00F);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
